// File: rtl/dram_pkg.sv
// Shared command/state encodings and default geometry/timing for the DRAM responder and its wrapper.
// Latency: none (types and a combinational decode helper); no backpressure.
package dram_pkg;

   localparam int DRAM_ROW_BITS = 11;
   localparam int DRAM_COL_BITS = 10;
   localparam int DRAM_T_RCD    = 5;
   localparam int DRAM_T_RP     = 5;
   localparam int DRAM_CL       = 5;
   localparam int CNT_W         = 8;

   typedef enum logic [2:0] {
      CMD_NOP,
      CMD_ACT,
      CMD_PRE,
      CMD_READ,
      CMD_WRITE,
      CMD_ILLEGAL
   } dram_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVATING,
      ST_ACTIVE,
      ST_PRECHARGING
   } bank_state_e;

   function automatic dram_cmd_e decode_cmd(input logic csn, input logic rasn,
                                            input logic casn, input logic [3:0] wen);
      dram_cmd_e c;
      c = CMD_ILLEGAL;
      if (csn || (rasn && casn))
         c = CMD_NOP;
      else if (!rasn && casn) begin
         if (wen == 4'hf)
            c = CMD_ACT;
         else if (wen == 4'h0)
            c = CMD_PRE;
      end else if (rasn && !casn)
         c = (wen == 4'hf) ? CMD_READ : CMD_WRITE;
      return c;
   endfunction

endpackage

// File: rtl/dram_array.sv
// Word-addressed storage with byte-masked synchronous write and combinational read.
// Latency: write commits at the edge, read is same-cycle; no backpressure.
module dram_array #(
   parameter int AW = 21
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [3:0]    we_n,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   localparam int DEPTH = 1 << AW;

   logic [31:0] mem [0:DEPTH-1];

   // Contents deliberately have no reset, like a real device.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (!we_n[i])
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dram_responder.sv
// Behavioural single-bank DRAM responder: command decode, open-row FSM with tRCD/tRP, CL read pipeline.
// Latency: READ at edge N gives DRAM_valid after edge N+CL-1; commands are never stalled, violations only flag.
module dram_responder
   import dram_pkg::*;
#(
   parameter int ROW_BITS = DRAM_ROW_BITS,
   parameter int COL_BITS = DRAM_COL_BITS,
   parameter int T_RCD    = DRAM_T_RCD,
   parameter int T_RP     = DRAM_T_RP,
   parameter int CL       = DRAM_CL
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                DRAM_CSn,
   input  logic [3:0]          DRAM_WEn,
   input  logic                DRAM_RASn,
   input  logic                DRAM_CASn,
   input  logic [ROW_BITS-1:0] DRAM_A,
   input  logic [31:0]         DRAM_D,
   output logic [31:0]         DRAM_Q,
   output logic                DRAM_valid,
   output logic                row_open,
   output logic                protocol_err
);

   dram_cmd_e            cmd;
   bank_state_e          state;
   logic [CNT_W-1:0]     cnt;
   logic [ROW_BITS-1:0]  open_row;
   logic                 viol;
   logic                 wr_en;
   logic                 rd_en;
   logic [31:0]          rd_data;
   logic [CL-1:0]        vld_pipe;
   logic [31:0]          dat_pipe [CL];

   assign cmd   = decode_cmd(DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn);
   assign wr_en = (cmd == CMD_WRITE) && (state == ST_ACTIVE);
   assign rd_en = (cmd == CMD_READ)  && (state == ST_ACTIVE);

   always_comb begin
      viol = 1'b0;
      case (cmd)
         CMD_ACT:              viol = (state != ST_IDLE);
         CMD_PRE:              viol = (state == ST_ACTIVATING) || (state == ST_PRECHARGING);
         CMD_READ, CMD_WRITE:  viol = (state != ST_ACTIVE);
         CMD_ILLEGAL:          viol = 1'b1;
         default:              viol = 1'b0;
      endcase
   end

   // The counter crossing to 0 moves the state, so the next edge already sees the new state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         open_row     <= '0;
         row_open     <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         if (viol)
            protocol_err <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (cmd == CMD_ACT) begin
                  open_row <= DRAM_A;
                  if (T_RCD <= 1) begin
                     state    <= ST_ACTIVE;
                     row_open <= 1'b1;
                  end else begin
                     state <= ST_ACTIVATING;
                     cnt   <= CNT_W'(T_RCD - 1);
                  end
               end
            end
            ST_ACTIVATING: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state    <= ST_ACTIVE;
                  row_open <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (cmd == CMD_PRE) begin
                  row_open <= 1'b0;
                  if (T_RP <= 1)
                     state <= ST_IDLE;
                  else begin
                     state <= ST_PRECHARGING;
                     cnt   <= CNT_W'(T_RP - 1);
                  end
               end
            end
            ST_PRECHARGING: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   dram_array #(
      .AW (ROW_BITS + COL_BITS)
   ) u_array (
      .clk   (clk),
      .wr_en (wr_en),
      .we_n  (DRAM_WEn),
      .addr  ({open_row, DRAM_A[COL_BITS-1:0]}),
      .wdata (DRAM_D),
      .rdata (rd_data)
   );

   // Data stages only advance behind a valid, so the last stage holds the previous read word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         for (int k = 0; k < CL; k++)
            dat_pipe[k] <= '0;
      end else begin
         vld_pipe[0] <= rd_en;
         if (rd_en)
            dat_pipe[0] <= rd_data;
         for (int k = 1; k < CL; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            if (vld_pipe[k-1])
               dat_pipe[k] <= dat_pipe[k-1];
         end
      end
   end

   assign DRAM_valid = vld_pipe[CL-1];
   assign DRAM_Q     = dat_pipe[CL-1];

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboarded bench for dram_responder: reads push expected word and due cycle, the monitor pops on DRAM_valid.
module tb_dram_responder;
   import dram_pkg::*;

   localparam int CL    = DRAM_CL;
   localparam int T_RCD = DRAM_T_RCD;
   localparam int T_RP  = DRAM_T_RP;

   typedef struct {
      logic [31:0] dat;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        DRAM_CSn = 1'b1;
   logic [3:0]  DRAM_WEn = 4'hf;
   logic        DRAM_RASn = 1'b1;
   logic        DRAM_CASn = 1'b1;
   logic [10:0] DRAM_A = '0;
   logic [31:0] DRAM_D = '0;
   logic [31:0] DRAM_Q;
   logic        DRAM_valid;
   logic        row_open;
   logic        protocol_err;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb [$];

   dram_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .DRAM_CSn     (DRAM_CSn),
      .DRAM_WEn     (DRAM_WEn),
      .DRAM_RASn    (DRAM_RASn),
      .DRAM_CASn    (DRAM_CASn),
      .DRAM_A       (DRAM_A),
      .DRAM_D       (DRAM_D),
      .DRAM_Q       (DRAM_Q),
      .DRAM_valid   (DRAM_valid),
      .row_open     (row_open),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && DRAM_valid) begin
         if (sb.size() == 0)
            check("valid_unexpected", 32'(DRAM_valid), 32'h0);
         else begin
            exp_t e;
            e = sb.pop_front();
            check("rd_cycle", cyc, e.due);
            check("rd_data", DRAM_Q, e.dat);
         end
      end
   end

   task automatic nop(input int n);
      DRAM_CSn = 1'b1; DRAM_RASn = 1'b1; DRAM_CASn = 1'b1; DRAM_WEn = 4'hf;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic rasn, input logic casn, input logic [3:0] wen,
                        input logic [10:0] a, input logic [31:0] d);
      DRAM_CSn = 1'b0; DRAM_RASn = rasn; DRAM_CASn = casn; DRAM_WEn = wen;
      DRAM_A = a; DRAM_D = d;
      @(posedge clk);
      #1;
      nop(0);
   endtask

   task automatic act(input logic [10:0] row);
      issue(1'b0, 1'b1, 4'hf, row, 32'h0);
   endtask

   task automatic pre();
      issue(1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
   endtask

   task automatic wr(input logic [9:0] col, input logic [3:0] wen, input logic [31:0] d);
      issue(1'b1, 1'b0, wen, {1'b0, col}, d);
   endtask

   // expect_ok: the read is legal and its data must emerge CL edges later
   task automatic rd(input logic [9:0] col, input logic [31:0] exp, input bit expect_ok);
      exp_t e;
      if (expect_ok) begin
         e.dat = exp;
         e.due = cyc + CL;
         sb.push_back(e);
      end
      issue(1'b1, 1'b0, 4'hf, {1'b0, col}, 32'h0);
   endtask

   task automatic do_reset();
      nop(0);
      rst_n = 1'b0;
      sb.delete();
      nop(2);
      rst_n = 1'b1;
      nop(1);
   endtask

   initial begin
      nop(3);
      check("rst_q", DRAM_Q, 32'h0);
      check("rst_valid", 32'(DRAM_valid), 32'h0);
      check("rst_row_open", 32'(row_open), 32'h0);
      check("rst_err", 32'(protocol_err), 32'h0);
      rst_n = 1'b1;
      nop(2);

      // Full write then read-after-write on the next edge
      act(11'h012);
      nop(3);
      check("row_open_early", 32'(row_open), 32'h0);
      nop(T_RCD - 4);
      wr(10'h003, 4'h0, 32'hDEADBEEF);
      check("row_open_active", 32'(row_open), 32'h1);
      rd(10'h003, 32'hDEADBEEF, 1'b1);
      nop(CL + 1);

      wr(10'h003, 4'b1010, 32'h11223344);
      rd(10'h003, 32'hDE22BE44, 1'b1);
      nop(CL + 1);

      // Back-to-back reads at the top of the column space
      wr(10'h3FE, 4'h0, 32'hA5A50001);
      wr(10'h3FF, 4'h0, 32'h5A5A0002);
      rd(10'h3FE, 32'hA5A50001, 1'b1);
      rd(10'h3FF, 32'h5A5A0002, 1'b1);
      nop(CL + 2);
      check("q_hold", DRAM_Q, 32'h5A5A0002);
      check("err_clean1", 32'(protocol_err), 32'h0);

      // Two rows sharing a column address keep separate words
      pre();
      nop(T_RP - 1);
      act(11'h001);
      nop(T_RCD - 1);
      wr(10'h000, 4'h0, 32'h11110001);
      pre();
      check("row_open_pre", 32'(row_open), 32'h0);
      nop(T_RP - 1);
      act(11'h002);
      nop(T_RCD - 1);
      wr(10'h000, 4'h0, 32'h22220002);
      rd(10'h000, 32'h22220002, 1'b1);
      pre();
      nop(T_RP - 1);
      act(11'h001);
      nop(T_RCD - 1);
      rd(10'h000, 32'h11110001, 1'b1);
      nop(CL + 1);
      check("err_clean2", 32'(protocol_err), 32'h0);

      // READ one edge before tRCD expires
      do_reset();
      act(11'h010);
      nop(T_RCD - 2);
      rd(10'h000, 32'h0, 1'b0);
      check("err_early_read", 32'(protocol_err), 32'h1);
      nop(CL + 2);

      // ACT while a row is already open
      do_reset();
      act(11'h010);
      nop(T_RCD - 1);
      act(11'h020);
      check("err_act_active", 32'(protocol_err), 32'h1);
      check("row_still_open", 32'(row_open), 32'h1);

      // ACT one edge before tRP expires
      do_reset();
      act(11'h010);
      nop(T_RCD - 1);
      pre();
      nop(T_RP - 2);
      act(11'h030);
      check("err_early_act", 32'(protocol_err), 32'h1);
      nop(T_RCD + 2);
      check("row_not_reopened", 32'(row_open), 32'h0);

      // All strobes low is not a valid command
      do_reset();
      issue(1'b0, 1'b0, 4'hf, 11'h0, 32'h0);
      check("err_illegal", 32'(protocol_err), 32'h1);

      // Reset while a read is in flight
      do_reset();
      act(11'h044);
      nop(T_RCD - 1);
      wr(10'h005, 4'h0, 32'hCAFEF00D);
      rd(10'h005, 32'hCAFEF00D, 1'b1);
      check("q_before_drop", DRAM_Q, 32'hDEADBEEF ^ 32'hDEADBEEF);
      nop(2);
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_q", DRAM_Q, 32'h0);
      check("mid_rst_valid", 32'(DRAM_valid), 32'h0);
      check("mid_rst_row_open", 32'(row_open), 32'h0);
      check("mid_rst_err", 32'(protocol_err), 32'h0);
      nop(CL + 2);
      rst_n = 1'b1;
      nop(1);
      act(11'h044);
      nop(T_RCD);
      check("post_rst_act_open", 32'(row_open), 32'h1);
      check("post_rst_act_err", 32'(protocol_err), 32'h0);
      rd(10'h005, 32'hCAFEF00D, 1'b1);
      nop(CL + 2);

      check("sb_drained", sb.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
